grey_to_binary_tracker: RTL and testbench
=========================================

Name: grey_to_binary_tracker

Overview:
- Receiving end of the binary-to-Gray path: accepts a stream of Gray-coded words over a valid/ready handshake and returns the registered binary equivalent.
- Checks that each accepted code differs from the previous accepted code in exactly one bit.
- Reports the count direction and keeps a saturating error count.
- Sits downstream of Gray-coded counters and pointers, e.g. async FIFO pointer consumers.

Parameters:
- WIDTH, 4, code width in bits (≥2).
- ERRW, 8, width of the error counter.

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  asynchronous active-low reset.
- G_VALID  input  1  Gray word on G is valid.
- G_READY  output  1  block can accept G this cycle.
- G  input  WIDTH  Gray-coded input word.
- BIN_VALID  output  1  BIN/flags hold a valid result.
- BIN_READY  input  1  downstream accepts result.
- BIN  output  WIDTH  binary equivalent of the accepted G.
- DIR_UP  output  1  result is previous binary value +1 (mod 2^WIDTH).
- DIR_DN  output  1  result is previous binary value −1 (mod 2^WIDTH).
- STEP_ERR  output  1  accepted code is not a single-bit change from the previous one.
- ERR_CNT  output  ERRW  saturating count of STEP_ERR events.

Behaviour:
- Reset (async assert, sync release): BIN_VALID=0, BIN=0, DIR_UP=0, DIR_DN=0, STEP_ERR=0, ERR_CNT=0, history-valid flag HAVE_PREV=0, previous-code register PREV=0.
- Handshake: G_READY = !BIN_VALID || BIN_READY (combinational, single output stage).
- Accept occurs when G_VALID && G_READY.
- On accept:
  - Result registers load next cycle; latency is 1 cycle.
  - BIN[WIDTH-1] = G[WIDTH-1]; BIN[i] = BIN[i+1] ^ G[i] for i from WIDTH-2 down to 0.
- Output hold:
  - BIN_VALID sets on accept.
  - BIN_VALID clears on BIN_READY without a new accept.
  - BIN_VALID stays 1 on simultaneous BIN_READY and accept, with results replaced.
- Stall: while BIN_VALID && !BIN_READY, BIN and all flags hold stable and G is ignored.
- Step check on accept, using Hamming distance d between G and PREV:
  - HAVE_PREV=0 (first word after reset): STEP_ERR=0, DIR_UP=0, DIR_DN=0.
  - d=1: STEP_ERR=0. DIR_UP=1 if BIN_new == BIN_prev+1 mod 2^WIDTH; otherwise DIR_DN=1. Exactly one of DIR_UP/DIR_DN is set.
  - d=0 (repeat): STEP_ERR=0, DIR_UP=0, DIR_DN=0.
  - d≥2: STEP_ERR=1, DIR_UP=0, DIR_DN=0.
- History update on every accept: PREV←G, BIN_prev←BIN_new, HAVE_PREV←1. Erroneous codes also become the new history.
- Wrap-around:
  - Gray 100..0 → 000..0 (binary max→0) is d=1 with DIR_UP=1.
  - The reverse transition gives DIR_DN=1.
- ERR_CNT:
  - Increments in the same cycle STEP_ERR is loaded as 1.
  - Saturates at 2^ERRW−1 and never wraps.
  - Cleared only by reset.
- Flags are qualified by BIN_VALID: they are per-result values, not pulses, and hold while stalled.
- Reset mid-operation: any pending result is discarded and history is lost. The next accepted word is treated as first.

Test Plan:
- Reset then full sweep, BIN_READY=1, G = Gray(0..15) = 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000 → BIN=0..15 each one cycle after accept. DIR_UP=1 from the second word onward, STEP_ERR=0, ERR_CNT=0.
- Wrap and reverse: send G=1000 then 0000 then 1000 → BIN=15,0,15. Second result DIR_UP=1, third DIR_DN=1.
- Backpressure: BIN_READY=0 with G_VALID=1 holding G=0011 after a result is pending → G_READY=0, BIN/flags frozen. Release BIN_READY → next word accepted same cycle, BIN=2 one cycle later.
- Step error: G=0000 then 0011 → second result BIN=2, STEP_ERR=1, DIR_UP=0, ERR_CNT=1. Then G=0010 (d=1 from 0011) → BIN=3, DIR_DN=0, DIR_UP=1, STEP_ERR=0.
- Saturation (ERRW=2): send 0000,0011,0000,0011,0000,0011 → ERR_CNT 1,2,3,3,3. Repeat word 0011,0011 → STEP_ERR=0, no direction flag.
- Async reset: assert RST_N=0 mid-stall between clock edges → BIN_VALID=0 and ERR_CNT=0 immediately. After release, the first word G=0110 yields BIN=4 with no flags.

Source files
------------

// File: rtl/grey_to_binary_tracker.sv
// Gray-code receiver: converts accepted Gray words to registered binary, classifies
// each step as up/down/repeat/illegal against the previous word, and counts illegal steps.
module grey_to_binary_tracker #(
   parameter int WIDTH = 4,
   parameter int ERRW  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             g_valid,
   output logic             g_ready,
   input  logic [WIDTH-1:0] g,
   output logic             bin_valid,
   input  logic             bin_ready,
   output logic [WIDTH-1:0] bin,
   output logic             dir_up,
   output logic             dir_dn,
   output logic             step_err,
   output logic [ERRW-1:0]  err_cnt
);

   localparam logic [WIDTH-1:0] BIN_ONE = WIDTH'(1);
   localparam logic [ERRW-1:0]  ERR_ONE = ERRW'(1);
   localparam logic [ERRW-1:0]  ERR_MAX = {ERRW{1'b1}};

   function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] code);
      logic [WIDTH-1:0] b;
      b = code;
      for (int i = WIDTH - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ code[i];
      end
      return b;
   endfunction

   function automatic int unsigned ones(input logic [WIDTH-1:0] v);
      int unsigned n;
      n = 32'd0;
      for (int i = 0; i < WIDTH; i++) begin
         n = n + 32'(v[i]);
      end
      return n;
   endfunction

   logic             bin_valid_r;
   logic [WIDTH-1:0] bin_r;
   logic             dir_up_r;
   logic             dir_dn_r;
   logic             step_err_r;
   logic [ERRW-1:0]  err_cnt_r;
   logic             have_prev_r;
   logic [WIDTH-1:0] prev_r;

   logic             accept_s;
   logic [WIDTH-1:0] bin_new_s;
   int unsigned      dist_s;
   logic             dir_up_s;
   logic             dir_dn_s;
   logic             step_err_s;

   // Single output stage: a new word may enter whenever the current result leaves or none is held.
   always_comb begin
      g_ready  = !bin_valid_r || bin_ready;
      accept_s = g_valid && g_ready;
   end

   // Step classification; bin_r always mirrors the previous accepted word's binary value.
   always_comb begin
      bin_new_s  = gray2bin(g);
      dist_s     = ones(g ^ prev_r);
      dir_up_s   = 1'b0;
      dir_dn_s   = 1'b0;
      step_err_s = 1'b0;
      if (have_prev_r) begin
         if (dist_s == 32'd1) begin
            if (bin_new_s == bin_r + BIN_ONE) begin
               dir_up_s = 1'b1;
            end else begin
               dir_dn_s = 1'b1;
            end
         end else if (dist_s > 32'd1) begin
            step_err_s = 1'b1;
         end else begin
            step_err_s = 1'b0;
         end
      end else begin
         step_err_s = 1'b0;
      end
   end

   // Result, history and error-count registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_valid_r <= 1'b0;
         bin_r       <= '0;
         dir_up_r    <= 1'b0;
         dir_dn_r    <= 1'b0;
         step_err_r  <= 1'b0;
         err_cnt_r   <= '0;
         have_prev_r <= 1'b0;
         prev_r      <= '0;
      end else if (accept_s) begin
         bin_valid_r <= 1'b1;
         bin_r       <= bin_new_s;
         dir_up_r    <= dir_up_s;
         dir_dn_r    <= dir_dn_s;
         step_err_r  <= step_err_s;
         have_prev_r <= 1'b1;
         prev_r      <= g;
         if (step_err_s && (err_cnt_r != ERR_MAX)) begin
            err_cnt_r <= err_cnt_r + ERR_ONE;
         end
      end else if (bin_ready) begin
         bin_valid_r <= 1'b0;
      end
   end

   assign bin_valid = bin_valid_r;
   assign bin       = bin_r;
   assign dir_up    = dir_up_r;
   assign dir_dn    = dir_dn_r;
   assign step_err  = step_err_r;
   assign err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_grey_to_binary_tracker.sv
// Directed bench for grey_to_binary_tracker: two instances (ERRW=8 and ERRW=2) share stimulus,
// a behavioural model is compared every cycle, plus hand-computed literal expectations.
module tb_grey_to_binary_tracker;

   logic       clk;
   logic       rst_n;
   logic       g_valid;
   logic [3:0] g;
   logic       bin_ready;

   logic       g_ready,  bin_valid,  dir_up,  dir_dn,  step_err;
   logic [3:0] bin;
   logic [7:0] err_cnt;
   logic       g_ready2, bin_valid2, dir_up2, dir_dn2, step_err2;
   logic [3:0] bin2;
   logic [1:0] err_cnt2;

   int checks = 0;
   int errors = 0;

   grey_to_binary_tracker #(.WIDTH(4), .ERRW(8)) dut (
      .clk(clk), .rst_n(rst_n), .g_valid(g_valid), .g_ready(g_ready), .g(g),
      .bin_valid(bin_valid), .bin_ready(bin_ready), .bin(bin),
      .dir_up(dir_up), .dir_dn(dir_dn), .step_err(step_err), .err_cnt(err_cnt)
   );

   grey_to_binary_tracker #(.WIDTH(4), .ERRW(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .g_valid(g_valid), .g_ready(g_ready2), .g(g),
      .bin_valid(bin_valid2), .bin_ready(bin_ready), .bin(bin2),
      .dir_up(dir_up2), .dir_dn(dir_dn2), .step_err(step_err2), .err_cnt(err_cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: binary value of a Gray word is the XOR of all its right shifts.
   function automatic int to_bin(input int code);
      int b;
      b = 0;
      for (int s = 0; s < 4; s++) b = b ^ (code >> s);
      return b & 15;
   endfunction

   logic m_valid, m_up, m_dn, m_err, m_have;
   int   m_bin, m_prev_code, m_cnt, m_cnt2;

   // Reference model of the handshake, classification and counters.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid <= 1'b0; m_up <= 1'b0; m_dn <= 1'b0; m_err <= 1'b0; m_have <= 1'b0;
         m_bin <= 0; m_prev_code <= 0; m_cnt <= 0; m_cnt2 <= 0;
      end else if (g_valid && (!m_valid || bin_ready)) begin
         m_valid     <= 1'b1;
         m_bin       <= to_bin(int'(g));
         m_up        <= m_have && ($countones(g ^ 4'(m_prev_code)) == 1) &&
                        (((to_bin(int'(g)) + 16 - m_bin) % 16) == 1);
         m_dn        <= m_have && ($countones(g ^ 4'(m_prev_code)) == 1) &&
                        (((to_bin(int'(g)) + 16 - m_bin) % 16) != 1);
         m_err       <= m_have && ($countones(g ^ 4'(m_prev_code)) >= 2);
         m_cnt       <= (m_have && ($countones(g ^ 4'(m_prev_code)) >= 2) && m_cnt < 255) ? m_cnt + 1 : m_cnt;
         m_cnt2      <= (m_have && ($countones(g ^ 4'(m_prev_code)) >= 2) && m_cnt2 < 3) ? m_cnt2 + 1 : m_cnt2;
         m_have      <= 1'b1;
         m_prev_code <= int'(g);
      end else if (bin_ready) begin
         m_valid <= 1'b0;
      end
   end

   // Per-cycle comparison of both instances against the model.
   always @(posedge clk) begin
      #1;
      if (rst_n) begin
         chk("g_ready", g_ready, !m_valid || bin_ready);
         chk("g_ready2", g_ready2, !m_valid || bin_ready);
         chk("bin_valid", bin_valid, m_valid);
         chk("bin_valid2", bin_valid2, m_valid);
         chk("err_cnt", err_cnt, m_cnt);
         chk("err_cnt2", err_cnt2, m_cnt2);
         if (m_valid) begin
            chk("bin", bin, m_bin);
            chk("dir_up", dir_up, m_up);
            chk("dir_dn", dir_dn, m_dn);
            chk("step_err", step_err, m_err);
            chk("bin2", bin2, m_bin);
            chk("step_err2", step_err2, m_err);
         end
      end
   end

   task automatic send(input logic [3:0] code, input logic rdy);
      int n;
      @(negedge clk);
      g = code; g_valid = 1'b1; bin_ready = rdy;
      #1;
      n = 0;
      while (!g_ready && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("send_ready", g_ready, 1'b1);
      @(posedge clk);
      #2;
      g_valid = 1'b0;
   endtask

   task automatic idle();
      @(negedge clk);
      g_valid = 1'b0; bin_ready = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   logic [3:0] sat_codes [6];
   int         sat_cnt2  [6];
   int         sat_cnt   [6];

   initial begin
      sat_codes = '{4'b0000, 4'b0011, 4'b0000, 4'b0011, 4'b0000, 4'b0011};
      sat_cnt2  = '{0, 1, 2, 3, 3, 3};
      sat_cnt   = '{0, 1, 2, 3, 4, 5};
      rst_n = 1'b0; g_valid = 1'b0; g = 4'd0; bin_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_valid", bin_valid, 1'b0);
      chk("rst_bin", bin, 4'd0);
      chk("rst_cnt", err_cnt, 8'd0);
      chk("rst_ready", g_ready, 1'b1);

      // Full sweep Gray(0..15)
      for (int i = 0; i < 16; i++) begin
         send(4'(i ^ (i >> 1)), 1'b1);
         chk("sweep_bin", bin, i);
         chk("sweep_up", dir_up, i > 0);
         chk("sweep_err", step_err, 1'b0);
      end
      chk("sweep_cnt", err_cnt, 8'd0);

      // Wrap and reverse
      send(4'b1000, 1'b1);
      chk("wrap_rep_bin", bin, 4'd15);
      chk("wrap_rep_up", dir_up, 1'b0);
      send(4'b0000, 1'b1);
      chk("wrap_bin", bin, 4'd0);
      chk("wrap_up", dir_up, 1'b1);
      send(4'b1000, 1'b1);
      chk("rev_bin", bin, 4'd15);
      chk("rev_dn", dir_dn, 1'b1);
      chk("rev_up", dir_up, 1'b0);

      // Backpressure
      send(4'b0000, 1'b1);
      idle();
      send(4'b0001, 1'b0);
      @(negedge clk);
      g = 4'b0011; g_valid = 1'b1; bin_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         chk("stall_ready", g_ready, 1'b0);
         chk("stall_bin", bin, 4'd1);
         chk("stall_valid", bin_valid, 1'b1);
      end
      @(negedge clk);
      bin_ready = 1'b1;
      #1;
      chk("release_ready", g_ready, 1'b1);
      @(posedge clk);
      #2;
      g_valid = 1'b0;
      chk("release_bin", bin, 4'd2);
      chk("release_up", dir_up, 1'b1);

      // Step error
      do_reset();
      send(4'b0000, 1'b1);
      send(4'b0011, 1'b1);
      chk("err_bin", bin, 4'd2);
      chk("err_flag", step_err, 1'b1);
      chk("err_up", dir_up, 1'b0);
      chk("err_cnt1", err_cnt, 8'd1);
      send(4'b0010, 1'b1);
      chk("after_err_bin", bin, 4'd3);
      chk("after_err_up", dir_up, 1'b1);
      chk("after_err_dn", dir_dn, 1'b0);
      chk("after_err_flag", step_err, 1'b0);

      // Saturation on the ERRW=2 instance
      do_reset();
      for (int i = 0; i < 6; i++) begin
         send(sat_codes[i], 1'b1);
         chk("sat_cnt2", err_cnt2, sat_cnt2[i]);
         chk("sat_cnt", err_cnt, sat_cnt[i]);
      end
      send(4'b0011, 1'b1);
      chk("repeat_err", step_err2, 1'b0);
      chk("repeat_up", dir_up2, 1'b0);
      chk("repeat_dn", dir_dn2, 1'b0);
      chk("repeat_cnt2", err_cnt2, 2'd3);

      // Async reset while stalled
      idle();
      send(4'b0001, 1'b0);
      @(negedge clk);
      g = 4'b0011; g_valid = 1'b1; bin_ready = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", bin_valid, 1'b0);
      chk("arst_cnt", err_cnt, 8'd0);
      chk("arst_cnt2", err_cnt2, 2'd0);
      @(negedge clk);
      rst_n = 1'b1; g_valid = 1'b0; bin_ready = 1'b1;
      send(4'b0110, 1'b1);
      chk("first_bin", bin, 4'd4);
      chk("first_valid", bin_valid, 1'b1);
      chk("first_up", dir_up, 1'b0);
      chk("first_dn", dir_dn, 1'b0);
      chk("first_err", step_err, 1'b0);

      repeat (3) idle();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
